// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Issues load/store requests to a data memory with an ack handshake, stalls
// upstream while the access is outstanding, aborts after DMEM_TIMEOUT
// cycles without an ack, and registers the MEM/WB results.
// Optional feature macro: MEM_ALIGN_CHECK_EN (drop misaligned word accesses
// and pulse o_misaligned); when undefined, DMEM address bits [1:0] are forced
// to zero and o_misaligned stays 0.
module mem_access_stage #(
  parameter int unsigned DMEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  input  logic [1:0]  i_ex_wb,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic [31:0] i_ex_alu_result,
  input  logic [31:0] i_ex_store_data,
  input  logic [4:0]  i_ex_write_reg,
  output logic        o_dmem_req_c,
  output logic        o_dmem_we_c,
  output logic [31:0] o_dmem_addr_c,
  output logic [31:0] o_dmem_wdata_c,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_stall_c,
  output logic [1:0]  o_wb_out,
  output logic [31:0] o_read_data_out,
  output logic [31:0] o_alu_result_out,
  output logic [4:0]  o_write_reg_out,
  output logic        o_mem_error,
  output logic        o_misaligned
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned CNT_W  = (DMEM_TIMEOUT < 1) ? 1 : $clog2(DMEM_TIMEOUT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Memory request captured when an access has to wait for its ack
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [WB_W-1:0]   wb;
    logic [REG_W-1:0]  wr;
  } mem_req_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  mem_req_t          r_req;
  logic [WB_W-1:0]   r_wb_out;
  logic [DATA_W-1:0] r_read_data_out;
  logic [DATA_W-1:0] r_alu_result_out;
  logic [REG_W-1:0]  r_write_reg_out;
  logic              r_mem_error;
  logic              r_misaligned;

  logic              w_mem_op;
  logic              w_misal;
  logic [DATA_W-1:0] w_addr_mask;
  logic              w_issue;
  logic              w_at_limit;
  logic              w_timeout;
  logic              w_req;
  logic              w_we;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_stall;

  assign w_mem_op = i_ex_mem_read | i_ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  // Misaligned memory ops are dropped instead of reaching the memory
  assign w_misal     = i_ex_valid & w_mem_op & (i_ex_alu_result[1:0] != 2'b00);
  assign w_addr_mask = '1;
`else
  // Word-aligned memory: the low address bits never reach the memory
  assign w_misal     = 1'b0;
  assign w_addr_mask = {{(DATA_W-2){1'b1}}, 2'b00};
`endif

  // Request decode, memory-side drive and upstream stall
  always_comb begin
    w_issue    = (r_state == S_IDLE) & i_ex_valid & w_mem_op & ~w_misal;
    w_at_limit = (r_cnt == CNT_W'(DMEM_TIMEOUT));
    w_timeout  = (r_state == S_WAIT) & w_at_limit & ~i_dmem_ack;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr     = i_ex_alu_result;
    w_wdata    = i_ex_store_data;
    w_stall    = 1'b0;
    if (r_state == S_WAIT) begin
      w_req   = ~w_timeout;
      w_we    = r_req.we & ~w_timeout;
      w_addr  = r_req.addr;
      w_wdata = r_req.wdata;
      w_stall = ~i_dmem_ack & ~w_timeout;
    end else begin
      w_req   = w_issue;
      w_we    = w_issue & i_ex_mem_write;
      w_stall = w_issue & ~i_dmem_ack;
    end
    w_addr = w_addr & w_addr_mask;
    // Reset silences the memory port and releases upstream immediately
    if (i_reset) begin
      w_req   = 1'b0;
      w_we    = 1'b0;
      w_stall = 1'b0;
    end
  end

  assign o_dmem_req_c   = w_req;
  assign o_dmem_we_c    = w_we;
  assign o_dmem_addr_c  = w_addr;
  assign o_dmem_wdata_c = w_wdata;
  assign o_stall_c      = w_stall;

  // FSM, wait counter, captured request and MEM/WB pipeline registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_req            <= '0;
      r_wb_out         <= '0;
      r_read_data_out  <= '0;
      r_alu_result_out <= '0;
      r_write_reg_out  <= '0;
      r_mem_error      <= 1'b0;
      r_misaligned     <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_ex_valid && !w_mem_op) begin
            r_wb_out         <= i_ex_wb;
            r_alu_result_out <= i_ex_alu_result;
            r_write_reg_out  <= i_ex_write_reg;
            r_read_data_out  <= '0;
          end else if (w_misal) begin
            r_wb_out         <= {1'b0, i_ex_wb[0]};
            r_alu_result_out <= i_ex_alu_result;
            r_write_reg_out  <= i_ex_write_reg;
            r_read_data_out  <= '0;
            r_misaligned     <= 1'b1;
          end else if (w_issue && i_dmem_ack) begin
            r_wb_out         <= i_ex_wb;
            r_alu_result_out <= i_ex_alu_result;
            r_write_reg_out  <= i_ex_write_reg;
            r_read_data_out  <= i_ex_mem_write ? '0 : i_dmem_rdata;
          end else if (w_issue) begin
            r_req <= '{addr:  i_ex_alu_result,
                       wdata: i_ex_store_data,
                       we:    i_ex_mem_write,
                       wb:    i_ex_wb,
                       wr:    i_ex_write_reg};
            r_cnt           <= '0;
            r_state         <= S_WAIT;
            r_wb_out        <= '0;
            r_write_reg_out <= '0;
          end else begin
            r_wb_out        <= '0;
            r_write_reg_out <= '0;
          end
        end
        S_WAIT: begin
          if (i_dmem_ack) begin
            r_wb_out         <= r_req.wb;
            r_alu_result_out <= r_req.addr;
            r_write_reg_out  <= r_req.wr;
            r_read_data_out  <= r_req.we ? '0 : i_dmem_rdata;
            r_state          <= S_IDLE;
          end else if (w_at_limit) begin
            r_wb_out         <= {1'b0, r_req.wb[0]};
            r_alu_result_out <= r_req.addr;
            r_write_reg_out  <= r_req.wr;
            r_read_data_out  <= '0;
            r_mem_error      <= 1'b1;
            r_state          <= S_IDLE;
          end else begin
            r_cnt           <= r_cnt + CNT_W'(1);
            r_wb_out        <= '0;
            r_write_reg_out <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_out         = r_wb_out;
  assign o_read_data_out  = r_read_data_out;
  assign o_alu_result_out = r_alu_result_out;
  assign o_write_reg_out  = r_write_reg_out;
  assign o_mem_error      = r_mem_error;
  assign o_misaligned     = r_misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage. The stimulus
// process also plays the data memory; expected MEM/WB results are derived
// from the stage's transfer rules and queued, and a monitor pops them when
// the stage accepts an instruction.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO    = 15;
  localparam int NEVER = 1000;

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        misal;
    logic        merr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_wb = '0;
  logic        ex_mr = 1'b0;
  logic        ex_mw = 1'b0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_sd = '0;
  logic [4:0]  ex_wr = '0;
  logic [31:0] dmem_rdata = '0;
  logic        ack = 1'b0;

  logic        o_dmem_req_c, o_dmem_we_c, o_stall_c;
  logic [31:0] o_dmem_addr_c, o_dmem_wdata_c;
  logic [1:0]  o_wb_out;
  logic [31:0] o_read_data_out, o_alu_result_out;
  logic [4:0]  o_write_reg_out;
  logic        o_mem_error, o_misaligned;

  exp_t        sb[$];
  logic [31:0] mem [logic [29:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        exp_err = 1'b0;

  mem_access_stage #(.DMEM_TIMEOUT(TO)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_ex_valid       (ex_valid),
    .i_ex_wb          (ex_wb),
    .i_ex_mem_read    (ex_mr),
    .i_ex_mem_write   (ex_mw),
    .i_ex_alu_result  (ex_alu),
    .i_ex_store_data  (ex_sd),
    .i_ex_write_reg   (ex_wr),
    .o_dmem_req_c     (o_dmem_req_c),
    .o_dmem_we_c      (o_dmem_we_c),
    .o_dmem_addr_c    (o_dmem_addr_c),
    .o_dmem_wdata_c   (o_dmem_wdata_c),
    .i_dmem_rdata     (dmem_rdata),
    .i_dmem_ack       (ack),
    .o_stall_c        (o_stall_c),
    .o_wb_out         (o_wb_out),
    .o_read_data_out  (o_read_data_out),
    .o_alu_result_out (o_alu_result_out),
    .o_write_reg_out  (o_write_reg_out),
    .o_mem_error      (o_mem_error),
    .o_misaligned     (o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Unwritten words read back as an address-derived pattern
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  // Monitor: compare MEM/WB outputs after each accepted instruction or bubble
  logic        acc_prev = 1'b0;
  logic [31:0] last_alu = '0;
  logic [31:0] last_rd = '0;
  logic        mon_err = 1'b0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      acc_prev = 1'b0;
      last_alu = '0;
      last_rd  = '0;
      mon_err  = 1'b0;
    end else begin
      if (acc_prev) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("wb_out", 32'(o_wb_out), 32'(mon_e.wb));
          check("write_reg_out", 32'(o_write_reg_out), 32'(mon_e.wr));
          check("alu_result_out", o_alu_result_out, mon_e.alu);
          check("read_data_out", o_read_data_out, mon_e.rd);
          check("misaligned", 32'(o_misaligned), 32'(mon_e.misal));
          check("mem_error", 32'(o_mem_error), 32'(mon_e.merr));
          last_alu = mon_e.alu;
          last_rd  = mon_e.rd;
          mon_err  = mon_e.merr;
        end
      end else begin
        check("bubble_wb", 32'(o_wb_out), 32'd0);
        check("bubble_wr", 32'(o_write_reg_out), 32'd0);
        check("bubble_alu_hold", o_alu_result_out, last_alu);
        check("bubble_rd_hold", o_read_data_out, last_rd);
        check("bubble_misaligned", 32'(o_misaligned), 32'd0);
        check("bubble_mem_error", 32'(o_mem_error), 32'(mon_err));
      end
      acc_prev = ex_valid & ~o_stall_c;
    end
  end

  // Present one instruction, act as the memory (ack lat cycles after the
  // request; NEVER = no ack), and hold it until the stage accepts it
  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] wb,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wreg, input int lat);
    exp_t e;
    logic memop, is_load, misal;
    int   cyc, stalls, reqs, exp_stalls, exp_reqs;
    bit   done;
    memop   = rd_en | wr_en;
    is_load = rd_en & ~wr_en;
    misal   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = memop & (a[1:0] != 2'b00);
`endif
    e.wb = wb; e.wr = wreg; e.alu = a; e.rd = '0; e.misal = 1'b0;
    exp_stalls = 0;
    exp_reqs   = 0;
    if (memop && misal) begin
      e.wb[1] = 1'b0;
      e.misal = 1'b1;
    end else if (memop && lat <= TO + 1) begin
      if (is_load) e.rd = mem_rd(a);
      exp_stalls = lat;
      exp_reqs   = lat + 1;
    end else if (memop) begin
      e.wb[1]    = 1'b0;
      exp_err    = 1'b1;
      exp_stalls = TO + 1;
      exp_reqs   = TO + 1;
    end
    e.merr = exp_err;
    sb.push_back(e);

    ex_valid = 1'b1; ex_mr = rd_en; ex_mw = wr_en; ex_wb = wb;
    ex_alu = a; ex_sd = sd; ex_wr = wreg;
    cyc = 0; stalls = 0; reqs = 0; done = 0;
    while (!done) begin
      if (memop && !misal) begin
        ack = (cyc == lat);
        dmem_rdata = ack ? mem_rd(a) : $urandom;
      end else begin
        ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      if (o_stall_c) stalls++;
      if (o_dmem_req_c) reqs++;
      if (cyc == 0) begin
        if (memop && !misal) begin
          check("req_issue", 32'(o_dmem_req_c), 32'd1);
          check("req_addr", o_dmem_addr_c, {a[31:2], 2'b00});
          check("req_we", 32'(o_dmem_we_c), 32'(wr_en));
          if (wr_en) check("req_wdata", o_dmem_wdata_c, sd);
        end else begin
          check("no_req", 32'(o_dmem_req_c), 32'd0);
        end
      end
      if (!o_stall_c) begin
        done = 1;
      end else if (cyc >= 60) begin
        n_checks++;
        $display("FAIL stall_bound: stall still high after %0d cycles, expected release", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (memop && !misal && wr_en && lat <= TO + 1) mem[a[31:2]] = sd;
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("req_cycles", 32'(reqs), 32'(exp_reqs));
    ex_valid = 1'b0;
    ack = 1'b0;
  endtask

  // Empty cycles with garbage control and spurious acks
  task automatic idle(input int n);
    repeat (n) begin
      ex_valid = 1'b0;
      ex_mr = 1'($urandom_range(0, 1));
      ex_mw = 1'($urandom_range(0, 1));
      ex_alu = $urandom;
      ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_req", 32'(o_dmem_req_c), 32'd0);
      check("idle_stall", 32'(o_stall_c), 32'd0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  initial begin
    #1000000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int kind, lat, r;
    logic [31:0] a;
    logic [1:0]  lo;

    // Reset state, with a memory op presented during reset
    ex_valid = 1'b1; ex_mr = 1'b1; ex_alu = 32'h0000_0040;
    #12;
    check("rst_req", 32'(o_dmem_req_c), 32'd0);
    check("rst_stall", 32'(o_stall_c), 32'd0);
    check("rst_we", 32'(o_dmem_we_c), 32'd0);
    check("rst_wb", 32'(o_wb_out), 32'd0);
    check("rst_mem_error", 32'(o_mem_error), 32'd0);
    ex_valid = 1'b0; ex_mr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    issue(1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0, 5'd5, 0);
    mem[30'h40] = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0, 5'd7, 3);
    issue(1'b0, 1'b1, 2'b00, 32'h0000_0040, 32'hA5A5_A5A5, 5'd0, 0);
    issue(1'b1, 1'b0, 2'b11, 32'h0000_0040, 32'h0, 5'd8, 2);
    issue(1'b1, 1'b0, 2'b11, 32'h0000_0080, 32'h0, 5'd9, NEVER);
    issue(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0, 5'd10, TO + 1);
    issue(1'b1, 1'b1, 2'b01, 32'h0000_0104, 32'h1357_9BDF, 5'd11, 1);
    issue(1'b1, 1'b0, 2'b11, 32'h0000_0102, 32'h0, 5'd12, 1);
    idle(2);

    // Reset in the second WAIT cycle discards the access
    ex_valid = 1'b1; ex_mr = 1'b1; ex_mw = 1'b0; ex_wb = 2'b11;
    ex_alu = 32'h0000_0200; ex_wr = 5'd9; ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_req", 32'(o_dmem_req_c), 32'd1);
    check("wait_stall", 32'(o_stall_c), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(o_dmem_req_c), 32'd0);
    check("async_rst_stall", 32'(o_stall_c), 32'd0);
    check("async_rst_wb", 32'(o_wb_out), 32'd0);
    check("async_rst_wr", 32'(o_write_reg_out), 32'd0);
    check("async_rst_alu", o_alu_result_out, 32'd0);
    check("async_rst_rd", o_read_data_out, 32'd0);
    check("async_rst_mem_error", 32'(o_mem_error), 32'd0);
    ex_valid = 1'b0; ex_mr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      r    = $urandom_range(0, 19);
      lat  = (r < 14) ? $urandom_range(0, 4) : (r < 18) ? $urandom_range(TO - 1, TO + 2) : NEVER;
      lo   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a    = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4 + 32'(lo);
      case (kind)
        0, 1, 2: issue(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
        3, 4, 5: issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)), lat);
        6, 7:    issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)), lat);
        8:       issue(1'b1, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)), lat);
        default: idle($urandom_range(1, 3));
      endcase
    end

    idle(2);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
